// File: rtl/pipeline_skid_register_pkg.sv
// rtl/pipeline_skid_register_pkg.sv - shared types and defaults for the skid register stage
package pipeline_skid_register_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [63:0] result;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic [1:0]  wb_sel;
  } mem_wb_t;

  localparam int DEFAULT_DATA_W = $bits(mem_wb_t);
  localparam int DEFAULT_CNT_W  = 16;

  function automatic logic [1:0] occ_of(state_e s);
    return (s == ST_FULL) ? 2'd2 : (s == ST_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipeline_skid_register_if.sv
// rtl/pipeline_skid_register_if.sv - upstream/downstream valid-ready handshake bundle
interface pipeline_skid_register_if
  import pipeline_skid_register_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipeline_skid_register_sat_counter.sv
// rtl/pipeline_skid_register_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_skid_register.sv
// rtl/pipeline_skid_register.sv - valid/ready pipeline register, two-entry skid or single-entry
module pipeline_skid_register
  import pipeline_skid_register_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      cnt_clear,
  pipeline_skid_register_if.slave   bus,
  output logic [CNT_W-1:0]          stall_count,
  output logic [1:0]                occupancy
);

  localparam bit SKID = (SKID_EN != 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic              out_valid;
  logic              accept;
  logic              emit;

  assign out_valid = (state_q != ST_EMPTY);
  assign emit      = out_valid & bus.out_ready;
  assign accept    = bus.in_valid & bus.in_ready;

  // Skid mode keeps in_ready registered so out_ready never reaches it combinationally.
  assign bus.in_ready  = SKID ? in_ready_q : (~out_valid | bus.out_ready);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = bus.in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_d = bus.in_data;
          end else if (accept && SKID) begin
            state_d = ST_FULL;
            skid_d  = bus.in_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
    occ_d      = occ_of(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_valid & ~bus.out_ready),
    .clr     (cnt_clear),
    .count   (stall_count)
  );

endmodule

// File: tb/tb_pipeline_skid_register.sv
// tb/tb_pipeline_skid_register.sv - directed and randomized checks of the skid register stage
module tb_pipeline_skid_register;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic        flush_a, clr_a, flush_s, clr_s, flush_p, clr_p;
  logic [15:0] stall_a, stall_p;
  logic [3:0]  stall_s;
  logic [1:0]  occ_a, occ_s, occ_p;

  logic [103:0] mq[$];
  int           mcnt;
  logic [127:0] rnd;
  logic         m_acc, m_emit, m_stall;

  pipeline_skid_register_if #(.DATA_W(104)) bus_a ();
  pipeline_skid_register_if #(.DATA_W(8))   bus_s ();
  pipeline_skid_register_if #(.DATA_W(8))   bus_p ();

  pipeline_skid_register #(.DATA_W(104), .SKID_EN(1), .CNT_W(16)) u_skid (
    .clk (clk), .reset_n (reset_n), .flush (flush_a), .cnt_clear (clr_a),
    .bus (bus_a), .stall_count (stall_a), .occupancy (occ_a)
  );

  pipeline_skid_register #(.DATA_W(8), .SKID_EN(1), .CNT_W(4)) u_sat (
    .clk (clk), .reset_n (reset_n), .flush (flush_s), .cnt_clear (clr_s),
    .bus (bus_s), .stall_count (stall_s), .occupancy (occ_s)
  );

  pipeline_skid_register #(.DATA_W(8), .SKID_EN(0), .CNT_W(16)) u_pass (
    .clk (clk), .reset_n (reset_n), .flush (flush_p), .cnt_clear (clr_p),
    .bus (bus_p), .stall_count (stall_p), .occupancy (occ_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    flush_a = 0; clr_a = 0; flush_s = 0; clr_s = 0; flush_p = 0; clr_p = 0;
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.out_ready = 0;
    bus_p.in_valid = 0; bus_p.in_data = '0; bus_p.out_ready = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
    chk("rst_out_data",  128'(bus_a.out_data),  128'(0));
    chk("rst_occ",       128'(occ_a),           128'(0));
    chk("rst_stall",     128'(stall_a),         128'(0));
    chk("rst_in_ready",  128'(bus_a.in_ready),  128'(0));
    reset_n = 1'b1;
    chk("rel_in_ready_pre", 128'(bus_a.in_ready), 128'(0));
    @(negedge clk);
    chk("rel_in_ready_post", 128'(bus_a.in_ready), 128'(1));

    // streaming 1..8
    bus_a.out_ready = 1;
    bus_a.in_valid  = 1;
    bus_a.in_data   = 104'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("str_valid", 128'(bus_a.out_valid), 128'(1));
      chk("str_data",  128'(bus_a.out_data),  128'(k));
      chk("str_ready", 128'(bus_a.in_ready),  128'(1));
      if (k < 8) bus_a.in_data = 104'(k + 1);
      else       bus_a.in_valid = 0;
    end
    @(negedge clk);
    chk("str_drain_valid", 128'(bus_a.out_valid), 128'(0));
    chk("str_stall",       128'(stall_a),         128'(0));

    // back-pressure
    bus_a.out_ready = 0;
    bus_a.in_valid  = 1;
    bus_a.in_data   = 104'hA;
    @(negedge clk);
    chk("bp_occ1", 128'(occ_a), 128'(1));
    bus_a.in_data = 104'hB;
    @(negedge clk);
    bus_a.in_valid = 0;
    repeat (2) @(negedge clk);
    chk("bp_occ2",   128'(occ_a),          128'(2));
    chk("bp_ready",  128'(bus_a.in_ready), 128'(0));
    chk("bp_hold",   128'(bus_a.out_data), 128'(104'hA));
    chk("bp_stall3", 128'(stall_a),        128'(3));
    bus_a.out_ready = 1;
    @(negedge clk);
    chk("bp_second",   128'(bus_a.out_data),  128'(104'hB));
    chk("bp_occ_back", 128'(occ_a),           128'(1));
    chk("bp_ready_up", 128'(bus_a.in_ready),  128'(1));
    @(negedge clk);
    chk("bp_empty", 128'(bus_a.out_valid), 128'(0));
    chk("bp_stall_keep", 128'(stall_a), 128'(3));

    // flush from FULL with an incoming beat
    bus_a.out_ready = 0;
    bus_a.in_valid  = 1;
    bus_a.in_data   = 104'h1;
    @(negedge clk);
    bus_a.in_data = 104'h2;
    @(negedge clk);
    chk("fl_full", 128'(occ_a), 128'(2));
    flush_a = 1;
    bus_a.in_data = 104'hC;
    @(negedge clk);
    chk("fl_valid", 128'(bus_a.out_valid), 128'(0));
    chk("fl_occ",   128'(occ_a),           128'(0));
    flush_a = 0;
    bus_a.in_valid = 0;
    bus_a.out_ready = 1;
    @(negedge clk);
    chk("fl_no_c", 128'(bus_a.out_valid), 128'(0));

    // flush from ONE with a simultaneous accept and emit: incoming beat dropped
    bus_a.out_ready = 0;
    bus_a.in_valid  = 1;
    bus_a.in_data   = 104'h77;
    @(negedge clk);
    flush_a = 1;
    bus_a.out_ready = 1;
    bus_a.in_data = 104'hC;
    @(negedge clk);
    flush_a = 0;
    bus_a.in_valid = 0;
    chk("fl1_valid", 128'(bus_a.out_valid), 128'(0));
    chk("fl1_occ",   128'(occ_a),           128'(0));
    @(negedge clk);
    chk("fl1_no_c", 128'(bus_a.out_valid), 128'(0));

    // saturation on CNT_W=4
    bus_s.in_valid = 1;
    bus_s.in_data  = 8'h5;
    @(negedge clk);
    bus_s.in_valid = 0;
    repeat (14) @(negedge clk);
    chk("sat_14", 128'(stall_s), 128'(14));
    repeat (6) @(negedge clk);
    chk("sat_15", 128'(stall_s), 128'(15));
    clr_s = 1;
    @(negedge clk);
    chk("sat_clr", 128'(stall_s), 128'(0));
    clr_s = 0;
    @(negedge clk);
    chk("sat_restart", 128'(stall_s), 128'(1));

    // single-entry mode
    bus_p.in_valid = 1;
    bus_p.in_data  = 8'h11;
    chk("pass_ready_empty", 128'(bus_p.in_ready), 128'(1));
    @(negedge clk);
    chk("pass_data1",   128'(bus_p.out_data), 128'(8'h11));
    chk("pass_blocked", 128'(bus_p.in_ready), 128'(0));
    bus_p.out_ready = 1;
    bus_p.in_data   = 8'h22;
    #1;
    chk("pass_comb_ready", 128'(bus_p.in_ready), 128'(1));
    @(negedge clk);
    chk("pass_data2", 128'(bus_p.out_data),  128'(8'h22));
    chk("pass_occ",   128'(occ_p),           128'(1));
    bus_p.in_valid = 0;
    @(negedge clk);
    chk("pass_empty", 128'(bus_p.out_valid), 128'(0));
    chk("pass_occ0",  128'(occ_p),           128'(0));

    // randomized run against a queue model
    bus_a.in_valid = 0;
    bus_a.out_ready = 0;
    clr_a = 1;
    @(negedge clk);
    clr_a = 0;
    mq.delete();
    mcnt = 0;
    for (int n = 0; n < 300; n++) begin
      chk("rnd_valid", 128'(bus_a.out_valid), 128'(mq.size() > 0));
      if (mq.size() > 0) chk("rnd_data", 128'(bus_a.out_data), 128'(mq[0]));
      chk("rnd_ready", 128'(bus_a.in_ready), 128'(mq.size() < 2));
      chk("rnd_occ",   128'(occ_a),          128'(mq.size()));
      chk("rnd_stall", 128'(stall_a),        128'(mcnt));
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_a.in_data   = rnd[103:0];
      bus_a.in_valid  = ($urandom_range(0, 3) != 0);
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      flush_a         = ($urandom_range(0, 31) == 0);
      clr_a           = ($urandom_range(0, 31) == 0);
      m_acc   = bus_a.in_valid && (mq.size() < 2);
      m_emit  = (mq.size() > 0) && bus_a.out_ready;
      m_stall = (mq.size() > 0) && !bus_a.out_ready;
      if (clr_a) mcnt = 0;
      else if (m_stall && mcnt < 65535) mcnt++;
      if (flush_a) begin
        mq.delete();
      end else begin
        if (m_emit) void'(mq.pop_front());
        if (m_acc)  mq.push_back(bus_a.in_data);
      end
      @(negedge clk);
    end

    // asynchronous reset while FULL
    bus_a.in_valid = 0;
    clr_a = 0;
    flush_a = 1;
    @(negedge clk);
    flush_a = 0;
    bus_a.out_ready = 0;
    bus_a.in_valid = 1;
    bus_a.in_data = 104'h55;
    @(negedge clk);
    bus_a.in_data = 104'h66;
    @(negedge clk);
    bus_a.in_valid = 0;
    chk("ar_full", 128'(occ_a), 128'(2));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 128'(bus_a.out_valid), 128'(0));
    chk("ar_occ",   128'(occ_a),           128'(0));
    chk("ar_ready", 128'(bus_a.in_ready),  128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ar_ready_pre", 128'(bus_a.in_ready), 128'(0));
    @(negedge clk);
    chk("ar_ready_post", 128'(bus_a.in_ready),  128'(1));
    chk("ar_still_empty", 128'(bus_a.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_register.md
PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

Interface
REQ-001 Parameter DATA_W, default 104, payload width in bits (packed stage fields).
REQ-002 Parameter SKID_EN, default 1; 1 = two-entry skid mode, 0 = single-entry mode with combinational ready.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous kill of all held and incoming beats.
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ready  output  1  block can accept a beat this cycle.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 cnt_clear  input  1  synchronous clear of stall_count.
REQ-015 stall_count  output  CNT_W  saturating count of back-pressured cycles.
REQ-016 occupancy  output  2  number of held beats (0..2).

Function
REQ-017 Accept = in_valid & in_ready; emit = out_valid & out_ready; beats leave in arrival order, payload unmodified.
REQ-018 SKID_EN=1: states EMPTY, ONE, FULL; main register drives out_*, skid register holds the overflow beat.
REQ-019 SKID_EN=1: in_ready = (state != FULL); it is a pure register output, with no combinational path from out_ready.
REQ-020 EMPTY: accept -> ONE, in_data loaded into main, out_valid=1 next cycle (latency 1).
REQ-021 ONE: accept & emit -> ONE with main reloaded; accept only -> FULL with in_data into skid; emit only -> EMPTY; neither -> ONE.
REQ-022 FULL: emit -> ONE with skid copied to main; no emit -> FULL, both registers held.
REQ-023 SKID_EN=0: single register; in_ready = ~out_valid | out_ready (combinational); occupancy is 0 or 1.
REQ-024 Full throughput: with in_valid and out_ready held at 1, one beat is emitted every cycle with no bubbles.
REQ-025 Data registers capture only on a load; held data stays stable while out_valid=1 and out_ready=0.
REQ-026 flush=1: next cycle state=EMPTY and out_valid=0, with priority over any simultaneous accept or emit; the incoming beat is dropped.
REQ-027 A downstream handshake asserted in the same cycle as flush still counts as an emit for the consumer.
REQ-028 stall_count increments by 1 each cycle with out_valid & ~out_ready and saturates at 2^CNT_W-1.
REQ-029 cnt_clear sets stall_count to 0 next cycle, with priority over an increment in the same cycle.
REQ-030 occupancy = 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-031 While reset_n=0: state=EMPTY, out_valid=0, out_data=0, skid data=0, stall_count=0, occupancy=0.
REQ-032 While reset_n=0 and in SKID_EN=1 mode, in_ready=0.
REQ-033 in_ready rises on the first clk edge after reset_n deasserts.
REQ-034 Reset asserted mid-transfer discards all held beats immediately, without waiting for a clock edge.

Structure
REQ-035 A shared package holds the state enum (EMPTY, ONE, FULL) and the default DATA_W and CNT_W constants.
REQ-036 The package holds the packed MEM/WB payload struct; its width sets the default DATA_W.
REQ-037 The saturating counter is one sub-module, sat_counter (parameter WIDTH; ports inc, clr, count), reused by other pipeline stages.

Verification
REQ-038 Streaming: SKID_EN=1, in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first accept, stall_count=0.
REQ-039 Back-pressure: accept 0xA then 0xB, out_ready=0 for 3 cycles -> occupancy=2, in_ready=0, out_data holds 0xA, stall_count=3; then out_ready=1 -> 0xA, 0xB emitted, in order.
REQ-040 Flush: FULL state, flush=1 with in_valid=1 (data 0xC) -> next cycle out_valid=0, occupancy=0, 0xC never emitted.
REQ-041 Saturation: CNT_W=4, 20 stalled cycles -> stall_count=15; cnt_clear with a stall in the same cycle -> 0.
REQ-042 SKID_EN=0: out_valid=1, out_ready=1, in_valid=1 in the same cycle -> in_ready=1 combinationally, the new beat is loaded, occupancy stays 1.
REQ-043 Async reset: reset_n pulsed low between clock edges while FULL -> out_valid=0 and occupancy=0 immediately; in_ready=1 on the first edge after release.
